// File: rtl/rx_serial_paralelo.sv
// rx_serial_paralelo: per-lane serial-to-parallel receiver.
// Finds byte alignment on COM symbols, requires SYNC_COUNT consecutive aligned
// COMs before declaring the lane active, then delivers payload bytes with a
// one-cycle valid. COM bytes seen while active are idle filler and carry no valid.
module rx_serial_paralelo #(
  parameter logic [7:0]  COM        = 8'hBC,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       byte_strobe
);

  localparam logic [3:0] SYNC_LIM = 4'(SYNC_COUNT);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_COUNT  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  sr_q, sr_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  com_cnt_q, com_cnt_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        valid_q, valid_d;
  logic        strobe_q, strobe_d;
  logic        active_q, active_d;
  logic [7:0]  nxt_s;
  logic        boundary_s;

  // Next-state and output logic: alignment search, COM counting, byte delivery.
  always_comb begin
    nxt_s      = {sr_q[6:0], data_in};
    boundary_s = (bit_cnt_q == 3'd7);
    sr_d       = nxt_s;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q + 3'd1;
    com_cnt_d  = com_cnt_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    strobe_d   = 1'b0;

    case (state_q)
      ST_SEARCH: begin
        // Sliding-window search: every bit position is a candidate alignment.
        bit_cnt_d = 3'd0;
        if (nxt_s == COM) begin
          com_cnt_d  = 4'd1;
          data_out_d = COM;
          strobe_d   = 1'b1;
          if (SYNC_LIM == 4'd1) begin
            state_d = ST_ACTIVE;
          end else begin
            state_d = ST_COUNT;
          end
        end else begin
          com_cnt_d = 4'd0;
        end
      end
      ST_COUNT: begin
        if (boundary_s) begin
          data_out_d = nxt_s;
          strobe_d   = 1'b1;
          if (nxt_s == COM) begin
            com_cnt_d = com_cnt_q + 4'd1;
            if ((com_cnt_q + 4'd1) == SYNC_LIM) begin
              state_d = ST_ACTIVE;
            end else begin
              state_d = ST_COUNT;
            end
          end else begin
            // Alignment broken: restart the search from the next bit.
            com_cnt_d = 4'd0;
            state_d   = ST_SEARCH;
          end
        end else begin
          state_d = ST_COUNT;
        end
      end
      ST_ACTIVE: begin
        // Only reset leaves ACTIVE; COM bytes are filler and get no valid.
        if (boundary_s) begin
          data_out_d = nxt_s;
          strobe_d   = 1'b1;
          valid_d    = (nxt_s != COM);
        end else begin
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_SEARCH;
        bit_cnt_d = 3'd0;
        com_cnt_d = 4'd0;
      end
    endcase

    active_d = (state_d == ST_ACTIVE);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_SEARCH;
      sr_q       <= 8'h00;
      bit_cnt_q  <= 3'd0;
      com_cnt_q  <= 4'd0;
      data_out_q <= 8'h00;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      com_cnt_q  <= com_cnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      strobe_q   <= strobe_d;
      active_q   <= active_d;
    end
  end

  assign data_out    = data_out_q;
  assign valid_out   = valid_q;
  assign active      = active_q;
  assign byte_strobe = strobe_q;

endmodule

// File: doc/rx_serial_paralelo.md
Name: rx_serial_paralelo

Overview:
- Per-lane receive deserializer that sits directly upstream of the lane recirculation stage.
- Takes one serial bit stream at bit rate and locks byte alignment on COM symbols (8'hBC).
- After enough consecutive aligned COMs it asserts lane active and emits payload bytes with a valid.
- Four instances feed data_in_0..3 / valid_in_0..3 of the recirculation stage; the top level derives that stage's idle select from the lanes' active outputs.

Parameters:
- COM, 8'hBC, comma/idle symbol used for alignment and as the filler byte.
- SYNC_COUNT, 4, consecutive aligned COMs required to enter ACTIVE (legal range 1..15).

Ports:
- clk  input  1  bit-rate clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  1  serial bit, MSB of each byte first.
- data_out  output  8  last completed aligned byte; holds between byte boundaries.
- valid_out  output  1  one-cycle pulse, high only for a non-COM byte delivered while in ACTIVE.
- active  output  1  high in ACTIVE state.
- byte_strobe  output  1  one-cycle pulse on every aligned byte boundary (COUNT or ACTIVE).

Behaviour:
- Shift register sr[7:0] captures data_in every cycle, MSB first: sr <= {sr[6:0], data_in}. On reset sr is cleared to 0.
- Reset values: data_out=8'h00, valid_out=0, active=0, byte_strobe=0, state=SEARCH, bit_cnt=0, com_cnt=0. While reset is high, sampled bits are discarded.
- Reset asserted mid-operation takes effect on that edge regardless of state; the first bit sampled after reset deasserts is the first bit considered.
- Define nxt = {sr[6:0], data_in}, the byte completed at the current edge.
- SEARCH:
  - Checked every cycle. If nxt==COM: bit_cnt<=0, com_cnt<=1, data_out<=COM, byte_strobe pulses.
  - Then go to ACTIVE if SYNC_COUNT==1, else COUNT. Otherwise stay.
- Byte boundaries in COUNT/ACTIVE: bit_cnt increments every cycle (mod 8). A boundary is an edge where bit_cnt==7.
- At each boundary: data_out<=nxt and byte_strobe pulses for one cycle.
- COUNT, at each boundary:
  - If nxt==COM: com_cnt<=com_cnt+1. If com_cnt+1==SYNC_COUNT, go to ACTIVE.
  - If nxt!=COM: com_cnt<=0, go to SEARCH. The next COM search begins with the following bit; earlier bits are not rescanned.
- ACTIVE:
  - At each boundary: if nxt!=COM, valid_out pulses; if nxt==COM, valid_out stays 0 (idle filler).
  - ACTIVE is left only by reset; no loss-of-sync detection.
- Outputs are registered. Latency: a byte's last bit sampled at edge N gives data_out/valid_out/byte_strobe visible after edge N, i.e. usable in cycle N+1.
- active rises on the same edge as the SYNC_COUNT-th COM's byte_strobe.
- valid_out and byte_strobe are never high for more than one consecutive cycle; valid_out implies byte_strobe.
- A COM split across an arbitrary bit offset after reset must still be found; there is no alignment assumption.
- A COM pattern straddling two aligned bytes in COUNT/ACTIVE is ignored.

Test Plan:
- Reset then 4 aligned COMs, then 8'h5A, 8'hC3 -> active high after 4th COM boundary; valid_out pulses with data_out=5A then C3, exactly 8 cycles apart.
- 3 stray bits (1,0,1) then 4 COMs, then 8'h11 -> lock at offset 3; data_out=8'h11 with valid_out at cycle 3+40 after reset release.
- 2 COMs, 8'h00, then 4 COMs, then 8'h22 -> return to SEARCH with no active; active only after the later 4 COMs; valid_out only for 22.
- ACTIVE stream 8'hA0, COM, 8'hA1 -> valid_out for A0 and A1 only; byte_strobe on all three; data_out=BC with valid_out=0 in between.
- Reset asserted mid-byte in ACTIVE -> next cycle active=0, data_out=00, valid_out=0; relock requires 4 fresh COMs.
- SYNC_COUNT=1 build, single COM then 8'h7E -> active on the COM edge; valid_out with data_out=7E 8 cycles later.
